// File: rtl/sb_track_if.sv
// Handshake bundle between the four track sources, the arbiter and the downstream track.
// The master side drives source data and downstream ready; the slave side is the arbiter.
interface sb_track_if #(parameter int W = 2);
  logic [3:0]     src_valid;
  logic [3:0]     src_last;
  logic [4*W-1:0] src_data;
  logic [3:0]     src_ready;
  logic           out_valid;
  logic           out_last;
  logic [W-1:0]   out_data;
  logic           out_ready;

  modport master (
    output src_valid, src_last, src_data, out_ready,
    input  src_ready, out_valid, out_last, out_data
  );

  modport slave (
    input  src_valid, src_last, src_data, out_ready,
    output src_ready, out_valid, out_last, out_data
  );
endinterface

// File: rtl/sb_track_arbiter.sv
// Output-track arbiter for a switch box: a fixed static route or round-robin with burst
// locking across four sources. The pass-through path is combinational and adds no latency.
module sb_track_arbiter #(
  parameter int W          = 2,
  parameter int MAXBURST_W = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        config_en,
  input  logic [1:0]  config_addr,
  input  logic [31:0] config_data,
  output logic [31:0] config_rdata,
  output logic [1:0]  sel,
  output logic        busy,
  sb_track_if.slave   trk
);

  localparam int CW = MAXBURST_W + 1;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t                state, state_n;
  logic                  mode;
  logic [1:0]            static_sel;
  logic [3:0]            mask;
  logic [MAXBURST_W-1:0] burst;
  logic [MAXBURST_W-1:0] burst_wr;
  logic [1:0]            dyn_sel, dyn_sel_n;
  logic [1:0]            ptr, ptr_n;
  logic [MAXBURST_W-1:0] beat_cnt, beat_cnt_n;
  logic [CW-1:0]         beat_next;
  logic                  beat_done;
  logic                  grant_active;
  logic                  out_valid_i;
  logic                  out_last_i;
  logic                  xfer;
  logic [3:0]            eligible;

  // First eligible source at or after start, walking upward modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] elig, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = start;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (elig[idx]) pick = idx;
    end
    return pick;
  endfunction

  assign burst_wr = config_data[MAXBURST_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode       <= 1'b0;
      static_sel <= 2'd3;
      mask       <= 4'hF;
      burst      <= MAXBURST_W'(1);
    end else if (config_en) begin
      case (config_addr)
        2'd0: begin
          mode       <= config_data[0];
          static_sel <= config_data[3:2];
        end
        2'd1: mask  <= config_data[3:0];
        2'd2: burst <= (burst_wr == '0) ? MAXBURST_W'(1) : burst_wr;
        default: ;
      endcase
    end
  end

  always_comb begin
    config_rdata = 32'd0;
    case (config_addr)
      2'd0:    config_rdata = {28'd0, static_sel, 1'b0, mode};
      2'd1:    config_rdata = {28'd0, mask};
      2'd2:    config_rdata = {{(32-MAXBURST_W){1'b0}}, burst};
      default: config_rdata = 32'd0;
    endcase
  end

  // Outputs are held off while reset is asserted, even though static routing is the reset mode.
  assign sel          = mode ? dyn_sel : static_sel;
  assign grant_active = reset_n & (mode ? ((state == GRANT) & mask[dyn_sel]) : mask[static_sel]);
  assign busy         = mode & grant_active;

  assign out_valid_i   = trk.src_valid[sel] & grant_active;
  assign out_last_i    = trk.src_last[sel] & out_valid_i;
  assign trk.out_valid = out_valid_i;
  assign trk.out_last  = out_last_i;
  assign trk.out_data  = trk.src_data[int'(sel)*W +: W];
  assign trk.src_ready = (trk.out_ready & grant_active) ? (4'b0001 << sel) : 4'b0000;

  assign xfer      = out_valid_i & trk.out_ready;
  assign eligible  = trk.src_valid & mask;
  assign beat_next = {1'b0, beat_cnt} + CW'(1);
  assign beat_done = beat_next >= {1'b0, burst};

  always_comb begin
    state_n    = state;
    dyn_sel_n  = dyn_sel;
    ptr_n      = ptr;
    beat_cnt_n = beat_cnt;
    if (!mode) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (|eligible) begin
            dyn_sel_n  = rr_pick(eligible, ptr);
            beat_cnt_n = '0;
            state_n    = GRANT;
          end
        end
        GRANT: begin
          if (!mask[dyn_sel]) begin
            state_n = IDLE;
            ptr_n   = dyn_sel + 2'd1;
          end else if (xfer) begin
            if (out_last_i || beat_done) begin
              state_n    = IDLE;
              ptr_n      = dyn_sel + 2'd1;
              beat_cnt_n = '0;
            end else begin
              beat_cnt_n = beat_next[MAXBURST_W-1:0];
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      dyn_sel  <= 2'd3;
      ptr      <= 2'd0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      dyn_sel  <= dyn_sel_n;
      ptr      <= ptr_n;
      beat_cnt <= beat_cnt_n;
    end
  end

endmodule

// File: tb/tb_sb_track_arbiter.sv
// Bench for sb_track_arbiter: directed scenarios with literal expectations, then random
// traffic and config writes compared every cycle against a cycle-level ownership model.
module tb_sb_track_arbiter;

  logic        clk;
  logic        reset_n;
  logic        config_en;
  logic [1:0]  config_addr;
  logic [31:0] config_data;
  logic [31:0] config_rdata;
  logic [1:0]  sel;
  logic        busy;

  sb_track_if #(.W(2)) trk ();

  sb_track_arbiter #(.W(2), .MAXBURST_W(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .config_en    (config_en),
    .config_addr  (config_addr),
    .config_data  (config_data),
    .config_rdata (config_rdata),
    .sel          (sel),
    .busy         (busy),
    .trk          (trk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  // Model: configuration, who owns the track, next round-robin start, beats moved.
  bit         m_mode;
  int         m_static;
  logic [3:0] m_mask;
  int         m_burst;
  bit         m_hold;
  int         m_sel;
  int         m_ptr;
  int         m_beats;
  int         grants[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int e_sel();
    return m_mode ? m_sel : m_static;
  endfunction

  function automatic bit e_act();
    if (!reset_n) return 1'b0;
    return m_mode ? (m_hold && m_mask[m_sel]) : m_mask[m_static];
  endfunction

  function automatic bit e_valid();
    return trk.src_valid[e_sel()] && e_act();
  endfunction

  function automatic logic [3:0] e_ready();
    return (trk.out_ready && e_act()) ? (4'b0001 << e_sel()) : 4'b0000;
  endfunction

  function automatic logic [31:0] e_rdata(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_static * 4 + int'(m_mode));
      2'd1:    return 32'(m_mask);
      2'd2:    return 32'(m_burst);
      default: return 32'd0;
    endcase
  endfunction

  function automatic int g_at(input int i);
    return (i < grants.size()) ? grants[i] : -1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    int sv, pv, bv, c;
    bit hv, xf;
    logic [3:0] el;
    if (!reset_n) begin
      m_mode   <= 1'b0;
      m_static <= 3;
      m_mask   <= 4'hF;
      m_burst  <= 1;
      m_hold   <= 1'b0;
      m_sel    <= 3;
      m_ptr    <= 0;
      m_beats  <= 0;
    end else begin
      sv = m_sel; pv = m_ptr; bv = m_beats; hv = m_hold;
      xf = e_valid() && trk.out_ready;
      if (!m_mode) begin
        hv = 1'b0;
      end else if (hv) begin
        if (!m_mask[sv]) begin
          hv = 1'b0;
          pv = (sv + 1) % 4;
        end else if (xf) begin
          bv++;
          if (trk.src_last[sv] || bv >= m_burst) begin
            hv = 1'b0;
            pv = (sv + 1) % 4;
            bv = 0;
          end
        end
      end else begin
        el = trk.src_valid & m_mask;
        if (el != 4'h0) begin
          for (int k = 0; k < 4; k++) begin
            c = (pv + k) % 4;
            if (el[c]) begin
              sv = c;
              break;
            end
          end
          hv = 1'b1;
          bv = 0;
          grants.push_back(sv);
        end
      end
      m_hold  <= hv;
      m_sel   <= sv;
      m_ptr   <= pv;
      m_beats <= bv;
      if (config_en) begin
        case (config_addr)
          2'd0: begin
            m_mode   <= config_data[0];
            m_static <= int'(config_data[3:2]);
          end
          2'd1: m_mask  <= config_data[3:0];
          2'd2: m_burst <= (config_data[3:0] == 4'h0) ? 1 : int'(config_data[3:0]);
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("out_valid", 32'(trk.out_valid), 32'(e_valid()));
      chk("out_last", 32'(trk.out_last), 32'(e_valid() && trk.src_last[e_sel()]));
      chk("out_data", 32'(trk.out_data), 32'(trk.src_data[e_sel()*2 +: 2]));
      chk("src_ready", 32'(trk.src_ready), 32'(e_ready()));
      chk("sel", 32'(sel), 32'(e_sel()));
      chk("busy", 32'(busy), 32'(m_mode && e_act()));
      chk("config_rdata", config_rdata, e_rdata(config_addr));
    end
  end

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    config_en = 1'b1; config_addr = a; config_data = d;
    @(posedge clk); #1;
    config_en = 1'b0;
  endtask

  task automatic wait_busy(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  int nxf;
  bit pat[5];

  initial begin
    reset_n = 1'b1; config_en = 1'b0; config_addr = 2'd0; config_data = 32'd0;
    trk.src_valid = 4'h8; trk.src_last = 4'h0; trk.src_data = 8'b1000_0000; trk.out_ready = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(trk.out_valid), 32'd0);
    chk("rst_src_ready", 32'(trk.src_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ctrl", config_rdata, 32'hC);
    chk_on = 1'b1;
    #9 reset_n = 1'b1;

    // Static route to pe_output after reset, then mask it off.
    @(negedge clk);
    chk("static_valid", 32'(trk.out_valid), 32'd1);
    chk("static_data", 32'(trk.out_data), 32'd2);
    chk("static_sel", 32'(sel), 32'd3);
    chk("static_ready", 32'(trk.src_ready), 32'h8);
    cfg_write(2'd1, 32'h7);
    @(negedge clk);
    chk("masked_valid", 32'(trk.out_valid), 32'd0);

    // Static reroute to in_2.
    cfg_write(2'd1, 32'hF);
    trk.src_valid = 4'h2; trk.src_data = 8'b0000_0100;
    cfg_write(2'd0, 32'h4);
    @(negedge clk);
    chk("reroute_sel", 32'(sel), 32'd1);
    chk("reroute_ready", 32'(trk.src_ready), 32'h2);
    chk("reroute_data", 32'(trk.out_data), 32'd1);

    // Round-robin, single-beat bursts, everyone valid.
    cfg_write(2'd2, 32'h1);
    trk.src_valid = 4'hF;
    grants.delete();
    cfg_write(2'd0, 32'h1);
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) chk("rr_order", 32'(g_at(i)), 32'(i % 4));

    // Burst of 3 under backpressure from source 2 only.
    cfg_write(2'd0, 32'h0);
    trk.src_valid = 4'h4;
    cfg_write(2'd2, 32'h3);
    cfg_write(2'd0, 32'h1);
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    wait_busy("burst_grant");
    nxf = (trk.out_valid && trk.out_ready) ? 1 : 0;
    for (int k = 1; k < 5; k++) begin
      @(posedge clk); #1;
      trk.out_ready = pat[k];
      @(negedge clk);
      if (trk.out_valid && trk.out_ready) nxf++;
    end
    @(posedge clk); #1;
    trk.src_valid = 4'h0; trk.out_ready = 1'b1;
    @(negedge clk);
    chk("burst_xfers", 32'(nxf), 32'd3);
    chk("burst_idle", 32'(busy), 32'd0);

    // Early last from source 0 ends a burst of 5 after two beats; source 1 follows.
    cfg_write(2'd0, 32'h0);
    trk.src_valid = 4'h3;
    cfg_write(2'd2, 32'h5);
    grants.delete();
    cfg_write(2'd0, 32'h1);
    wait_busy("last_grant");
    @(posedge clk); #1;
    trk.src_last = 4'h1;
    @(negedge clk);
    chk("last_out_last", 32'(trk.out_last), 32'd1);
    @(posedge clk); #1;
    trk.src_last = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("last_first", 32'(g_at(0)), 32'd0);
    chk("last_next", 32'(g_at(1)), 32'd1);

    // Masking the owner mid-grant drops it and advances the pointer past it.
    cfg_write(2'd0, 32'h0);
    trk.src_valid = 4'h8;
    cfg_write(2'd2, 32'hF);
    cfg_write(2'd0, 32'h1);
    wait_busy("mask_grant");
    chk("mask_owner", 32'(sel), 32'd3);
    cfg_write(2'd1, 32'h7);
    @(negedge clk);
    chk("mask_drop_busy", 32'(busy), 32'd0);
    chk("mask_drop_valid", 32'(trk.out_valid), 32'd0);
    trk.src_valid = 4'h0;
    cfg_write(2'd1, 32'hF);
    trk.src_valid = 4'hA;
    grants.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("mask_ptr_next", 32'(g_at(0)), 32'd1);

    // Asynchronous reset in the middle of a burst.
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(trk.out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ready", 32'(trk.src_ready), 32'd0);
    chk("arst_sel", 32'(sel), 32'd3);
    config_addr = 2'd0; #1;
    chk("arst_ctrl", config_rdata, 32'hC);
    config_addr = 2'd1; #1;
    chk("arst_mask", config_rdata, 32'hF);
    config_addr = 2'd2; #1;
    chk("arst_burst", config_rdata, 32'h1);
    @(negedge clk); #2;
    reset_n = 1'b1;

    // Random traffic with sporadic config writes, including address 3 and burst 0.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      trk.src_valid = 4'($urandom);
      trk.src_last  = 4'($urandom);
      trk.src_data  = 8'($urandom);
      trk.out_ready = ($urandom_range(3) != 0);
      config_addr   = 2'($urandom);
      config_data   = $urandom;
      if (config_addr == 2'd0) config_data[0] = ($urandom_range(3) != 0);
      config_en     = ($urandom_range(15) == 0);
    end
    @(posedge clk); #1;
    config_en = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sb_track_arbiter.md
Name: sb_track_arbiter

Overview:
- Dynamic arbiter/scheduler for one switch-box output track (width W), shared by four sources.
- Source index matches the switch-box mux select encoding: 0=in_0, 1=in_2, 2=in_3, 3=pe_output.
- Runs either a static route (the fixed configured select) or round-robin arbitration with burst locking, using valid/ready handshakes.
- Drives the track data/valid and exports the current select so the switch-box config field can be mirrored.

Parameters:
- W, 2, track data width.
- MAXBURST_W, 4, width of burst-length field; max burst = 2^MAXBURST_W - 1.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- config_en  in  1  config write strobe.
- config_addr  in  2  0=CTRL, 1=MASK, 2=BURST.
- config_data  in  32  write data.
- config_rdata  out  32  readback of the register at config_addr, combinational.
- src_valid  in  4  per-source valid.
- src_last  in  4  per-source end-of-packet, qualified by valid.
- src_data  in  4*W  source s occupies bits [s*W +: W].
- src_ready  out  4  per-source ready.
- out_valid  out  1  track valid.
- out_last  out  1  track end-of-packet.
- out_data  out  W  track data.
- out_ready  in  1  downstream ready.
- sel  out  2  current select (mux encoding).
- busy  out  1  a grant is held.

Behaviour:
- Registers, reset values:
  - CTRL[0] mode: 0=static, 1=dynamic. Reset 0.
  - CTRL[3:2] static_sel. Reset 2'd3.
  - MASK[3:0] enable per source. Reset 4'hF.
  - BURST[MAXBURST_W-1:0] burst length. Reset 1. Written value 0 is treated as 1.
- Unused register bits read 0. Write takes effect the cycle after config_en. Unmapped address 3: write ignored, reads 0.
- Datapath:
  - out_data = src_data[sel]; out_valid = src_valid[sel] & grant_active; out_last = src_last[sel] & out_valid.
  - src_ready[s] = out_ready & grant_active & (sel==s); all other bits are 0.
  - Pass-through path is combinational; zero added latency.
- Static mode:
  - grant_active = MASK[static_sel]; sel = static_sel; busy = 0.
  - No arbitration state changes.
- Dynamic mode FSM (IDLE, GRANT):
  - IDLE: eligible = src_valid & MASK. If eligible is nonzero, pick the first eligible source at or after ptr in round-robin order (ptr, ptr+1, ... mod 4).
  - On the pick, register sel, load beat_cnt=0, go to GRANT. Arbitration takes 1 cycle; no data is transferred in IDLE.
  - GRANT: grant_active=1, busy=1. Each transfer (out_valid & out_ready) increments beat_cnt.
  - Leave GRANT at the transfer cycle where out_last=1, or where beat_cnt+1 == burst length.
  - On exit: ptr = sel+1 (mod 4), state goes to IDLE next cycle.
  - A masked-off source holding a grant (MASK cleared mid-grant) drops the grant the next cycle with no further transfers; ptr advances.
  - If src_valid drops mid-grant, the grant is held and the beat is not counted.
- sel holds its last value in IDLE. Reset: sel=3, ptr=0, state=IDLE, beat_cnt=0.
- Mode written 1→0 mid-grant: FSM forced to IDLE next cycle, static routing applies from that cycle.
- Config write coinciding with a transfer: the transfer completes under the old settings.
- Outputs at reset: out_valid=0, src_ready=0, busy=0, out_last=0, config_rdata reflects reset registers.
- Asynchronous reset assertion mid-packet clears all state immediately. The packet is truncated; no recovery.

Test Plan:
- Reset/static: after reset, src_valid=4'h8, pe data 2'b10, out_ready=1 → out_valid=1, out_data=2'b10, sel=3, src_ready=4'h8. Then write MASK=4'h7 → out_valid=0.
- Static reroute: write CTRL static_sel=1, src_valid=4'h2 → sel=1 next cycle, src_ready=4'h2; other sources stay ready=0.
- Round-robin: mode=1, BURST=1, all four valid continuously, out_ready=1 → grant order 0,1,2,3,0. Each grant takes one idle cycle plus one transfer.
- Burst/backpressure: BURST=3, only src 2 valid, out_ready toggles 1,0,1,0,1 → exactly 3 transfers, then IDLE. beat_cnt does not advance on ready=0 cycles.
- Early last: BURST=5, src 0 asserts last on beat 2 → grant released after beat 2; ptr=1, and src 1 wins next if valid.
- Mid-grant disruptions: mask src 3 during its grant → grant dropped next cycle, ptr=0. Then assert reset_n=0 mid-burst → outputs 0 immediately, registers return to reset values.
